// File: rtl/sm3_block_scheduler_if.sv
// Byte-stream input and block output handshakes of the SM3 block scheduler.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface sm3_block_scheduler_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  // scheduler side
  modport slave (
    input  in_valid, in_byte, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

  // producer / compression-core side
  modport master (
    output in_valid, in_byte, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sm3_block_scheduler.sv
// Packs a byte stream into 512-bit SM3 blocks and applies SM3 padding (0x80, zero fill,
// 64-bit big-endian bit length), emitting an extra block when the tail leaves no room.
module sm3_block_scheduler (
  input  logic                    clk,
  input  logic                    rst_n,
  sm3_block_scheduler_if.slave    bus,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_PAD   = 3'd2,
    S_EMIT  = 3'd3,
    S_EXTRA = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [60:0]   total_q, total_d;
  logic [511:0]  blk_q, blk_d;
  logic          last_q, last_d;
  logic          need_extra_q, need_extra_d;
  logic          extra_marker_q, extra_marker_d;
  logic          busy_q, busy_d;

  logic          accepting;
  logic          in_accept;
  logic [6:0]    pad_p;
  logic [63:0]   bit_len;

  assign accepting = rst_n && (state_q == S_IDLE || state_q == S_FILL);
  assign in_accept = accepting && bus.in_valid;
  // In PAD, cnt has already advanced past the last byte; a wrap to 0 means the block filled up.
  assign pad_p     = (cnt_q == 6'd0) ? 7'd64 : {1'b0, cnt_q};
  assign bit_len   = {total_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      total_q        <= '0;
      blk_q          <= '0;
      last_q         <= 1'b0;
      need_extra_q   <= 1'b0;
      extra_marker_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      total_q        <= total_d;
      blk_q          <= blk_d;
      last_q         <= last_d;
      need_extra_q   <= need_extra_d;
      extra_marker_q <= extra_marker_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    total_d        = total_q;
    blk_d          = blk_q;
    last_d         = last_q;
    need_extra_d   = need_extra_q;
    extra_marker_d = extra_marker_q;
    busy_d         = busy_q;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (in_accept) begin
          for (int k = 0; k < 64; k++) begin
            if (cnt_q == 6'(k)) blk_d[511-8*k -: 8] = bus.in_byte;
          end
          cnt_d   = cnt_q + 6'd1;
          total_d = total_q + 61'd1;
          busy_d  = 1'b1;
          state_d = S_FILL;
          if (bus.in_last) begin
            state_d = S_PAD;
          end else if (cnt_q == 6'd63) begin
            state_d      = S_EMIT;
            last_d       = 1'b0;
            need_extra_d = 1'b0;
          end
        end
      end

      S_PAD: begin
        for (int k = 0; k < 64; k++) begin
          if (7'(k) == pad_p)     blk_d[511-8*k -: 8] = 8'h80;
          else if (7'(k) > pad_p) blk_d[511-8*k -: 8] = 8'h00;
        end
        if (pad_p <= 7'd55) begin
          blk_d[63:0]  = bit_len;
          last_d       = 1'b1;
          need_extra_d = 1'b0;
        end else begin
          last_d         = 1'b0;
          need_extra_d   = 1'b1;
          extra_marker_d = (pad_p == 7'd64);
        end
        state_d = S_EMIT;
      end

      S_EMIT: begin
        if (bus.blk_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            total_d = '0;
            last_d  = 1'b0;
          end else if (need_extra_q) begin
            state_d = S_EXTRA;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_EXTRA: begin
        blk_d          = '0;
        blk_d[511:504] = extra_marker_q ? 8'h80 : 8'h00;
        blk_d[63:0]    = bit_len;
        last_d         = 1'b1;
        need_extra_d   = 1'b0;
        state_d        = S_EMIT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = accepting;
  assign bus.blk_valid = (state_q == S_EMIT);
  assign bus.blk_data  = blk_q;
  assign bus.blk_last  = last_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule
